// File: rtl/tape_mag_in_detector.sv
// Cassette MAG IN front end.
// Turns the signed 16-bit tape_audio stream from the playback block into the
// 1-bit level the 9901 samples. The path runs in three stages:
//   1. A DC-blocking tracker removes the slow offset from the audio.
//   2. A hysteresis comparator qualifies each sample as clearly up or clearly down.
//   3. A glitch filter accepts a transition only after MIN_STABLE consecutive
//      qualifying ticks.
// The block also measures the half-period, in ticks, between accepted edges.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   clk_3mhz_en  3 MHz tick enable; datapath state only advances on it
//   enable       motor control (CS1); low forces the idle state on a tick
//   tape_audio   signed two's complement sample, bit 0 is the sign
//   mag_in       filtered cassette level
//   edge_strobe  one-clk pulse on each accepted transition
//   half_period  ticks between the last two accepted transitions, saturating
module tape_mag_in_detector #(
  parameter logic [15:0] HYST       = 16'd1024,
  parameter int unsigned DC_SHIFT   = 10,
  parameter int unsigned MIN_STABLE = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_3mhz_en,
  input  logic        enable,
  input  logic [0:15] tape_audio,
  output logic        mag_in,
  output logic        edge_strobe,
  output logic [0:11] half_period
);

  localparam int unsigned AccW      = 16 + DC_SHIFT;
  localparam logic [3:0]  MinStable = 4'(MIN_STABLE);

  localparam logic [1:0] StLow      = 2'd0;
  localparam logic [1:0] StRisePend = 2'd1;
  localparam logic [1:0] StHigh     = 2'd2;
  localparam logic [1:0] StFallPend = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [3:0]             stable_q, stable_d;
  logic signed [AccW-1:0] dc_acc_q, dc_acc_d;
  logic [11:0]            period_q, period_d;
  logic [11:0]            hp_q, hp_d;
  logic                   strobe_q, strobe_d;

  // DC tracker: dc_acc holds the running mean scaled by 2^DC_SHIFT.
  logic signed [15:0]     audio;
  logic signed [AccW-1:0] audio_ext;
  logic signed [AccW-1:0] dc_full;
  logic signed [15:0]     dc;
  logic signed [AccW-1:0] dc_ext;
  logic signed [AccW-1:0] dc_acc_next;

  assign audio       = $signed(tape_audio);
  assign audio_ext   = {{DC_SHIFT{audio[15]}}, audio};
  assign dc_full     = dc_acc_q >>> DC_SHIFT;
  assign dc          = dc_full[15:0];
  assign dc_ext      = {{DC_SHIFT{dc[15]}}, dc};
  assign dc_acc_next = dc_acc_q + audio_ext - dc_ext;

  // 17-bit difference cannot overflow for any pair of 16-bit operands.
  logic signed [16:0] ac;
  logic signed [16:0] hyst_p;
  logic signed [16:0] hyst_n;
  logic               up;
  logic               dn;

  assign ac     = {audio[15], audio} - {dc[15], dc};
  assign hyst_p = {1'b0, HYST};
  assign hyst_n = -hyst_p;
  assign up     = (ac > hyst_p);
  assign dn     = (ac < hyst_n);

  logic [11:0] period_inc;
  logic [3:0]  stable_inc;
  logic        accept;

  assign period_inc = (period_q == 12'hfff) ? period_q : period_q + 12'd1;
  assign stable_inc = stable_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    dc_acc_d = dc_acc_q;
    period_d = period_q;
    hp_d     = hp_q;
    strobe_d = 1'b0;
    accept   = 1'b0;
    if (clk_3mhz_en) begin
      if (!enable) begin
        // Motor off: idle everything except the last measured half-period.
        state_d  = StLow;
        stable_d = '0;
        dc_acc_d = '0;
        period_d = '0;
      end else begin
        dc_acc_d = dc_acc_next;
        case (state_q)
          StLow: begin
            if (up) begin
              if (MinStable == 4'd1) begin
                state_d  = StHigh;
                stable_d = '0;
                accept   = 1'b1;
              end else begin
                state_d  = StRisePend;
                stable_d = 4'd1;
              end
            end
          end
          StRisePend: begin
            if (up) begin
              if (stable_inc == MinStable) begin
                state_d  = StHigh;
                stable_d = '0;
                accept   = 1'b1;
              end else begin
                stable_d = stable_inc;
              end
            end else begin
              state_d  = StLow;
              stable_d = '0;
            end
          end
          StHigh: begin
            if (dn) begin
              if (MinStable == 4'd1) begin
                state_d  = StLow;
                stable_d = '0;
                accept   = 1'b1;
              end else begin
                state_d  = StFallPend;
                stable_d = 4'd1;
              end
            end
          end
          StFallPend: begin
            if (dn) begin
              if (stable_inc == MinStable) begin
                state_d  = StLow;
                stable_d = '0;
                accept   = 1'b1;
              end else begin
                stable_d = stable_inc;
              end
            end else begin
              state_d  = StHigh;
              stable_d = '0;
            end
          end
          default: begin
            state_d  = StLow;
            stable_d = '0;
          end
        endcase
        if (accept) begin
          hp_d     = period_inc;
          period_d = '0;
          strobe_d = 1'b1;
        end else begin
          period_d = period_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StLow;
      stable_q <= '0;
      dc_acc_q <= '0;
      period_q <= '0;
      hp_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      dc_acc_q <= dc_acc_d;
      period_q <= period_d;
      hp_q     <= hp_d;
      strobe_q <= strobe_d;
    end
  end

  // The pending-fall state still reports the high level until the fall is accepted.
  assign mag_in      = (state_q == StHigh) || (state_q == StFallPend);
  assign edge_strobe = strobe_q;
  assign half_period = hp_q;

endmodule

// File: tb/tb_tape_mag_in_detector.sv
module tb_tape_mag_in_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_tick, a_en, a_mag, a_stb;
  logic [15:0] a_audio;
  logic [11:0] a_hp;
  logic        b_tick, b_en, b_mag, b_stb;
  logic [15:0] b_audio;
  logic [11:0] b_hp;

  typedef struct packed {
    logic        mag;
    logic [11:0] hp;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   gap   = 0;

  tape_mag_in_detector u_dut_a (
    .clk         (clk),
    .reset       (rst),
    .clk_3mhz_en (a_tick),
    .enable      (a_en),
    .tape_audio  (a_audio),
    .mag_in      (a_mag),
    .edge_strobe (a_stb),
    .half_period (a_hp)
  );

  tape_mag_in_detector #(
    .DC_SHIFT (14)
  ) u_dut_b (
    .clk         (clk),
    .reset       (rst),
    .clk_3mhz_en (b_tick),
    .enable      (b_en),
    .tape_audio  (b_audio),
    .mag_in      (b_mag),
    .edge_strobe (b_stb),
    .half_period (b_hp)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input bit sel, input bit mag, input int hp);
    exp_t e;
    e.mag = mag;
    e.hp  = 12'(hp);
    if (sel) b_q.push_back(e);
    else     a_q.push_back(e);
  endtask

  // n ticks of one sample value, each followed by `gap` idle clocks.
  task automatic drive(input bit sel, input int val, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel) begin b_audio = 16'(val); b_tick = 1'b1; end
      else     begin a_audio = 16'(val); a_tick = 1'b1; end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        a_tick = 1'b0;
        b_tick = 1'b0;
      end
    end
    @(negedge clk);
    a_tick = 1'b0;
    b_tick = 1'b0;
  endtask

  // Monitor: every strobe must match the next queued edge.
  always @(negedge clk) begin
    exp_t e;
    if (a_stb) begin
      if (a_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_edge: got edge mag=%0d hp=%0d, required none", a_mag, a_hp);
      end else begin
        e = a_q.pop_front();
        check("a_edge_mag", int'(a_mag), int'(e.mag));
        check("a_edge_hp", int'(a_hp), int'(e.hp));
      end
    end
    if (b_stb) begin
      if (b_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_edge: got edge mag=%0d hp=%0d, required none", b_mag, b_hp);
      end else begin
        e = b_q.pop_front();
        check("b_edge_mag", int'(b_mag), int'(e.mag));
        check("b_edge_hp", int'(b_hp), int'(e.hp));
      end
    end
  end

  initial begin
    rst     = 1'b1;
    a_tick  = 1'b0;
    a_en    = 1'b1;
    a_audio = '0;
    b_tick  = 1'b0;
    b_en    = 1'b1;
    b_audio = '0;
    repeat (3) @(negedge clk);
    check("rst_a_mag", int'(a_mag), 0);
    check("rst_a_stb", int'(a_stb), 0);
    check("rst_a_hp", int'(a_hp), 0);
    check("rst_b_mag", int'(b_mag), 0);
    check("rst_b_hp", int'(b_hp), 0);
    rst = 1'b0;

    // Silence: no edges at all.
    drive(0, 0, 10000);
    check("silence_mag", int'(a_mag), 0);

    // Glitch filter, with idle clocks between ticks.
    gap = 2;
    drive(0, 8000, 2);
    check("two_tick_mag", int'(a_mag), 0);
    drive(0, 0, 5);
    check("after_glitch_mag", int'(a_mag), 0);
    push(0, 1, 4095);
    drive(0, 8000, 3);
    check("third_tick_mag", int'(a_mag), 1);
    gap = 0;

    // Square wave +-8000, 500-tick halves; the rise above is its first edge.
    drive(0, 8000, 497);
    for (int k = 0; k < 5; k++) begin
      push(0, k % 2, 500);
      drive(0, (k % 2 == 1) ? 8000 : -8000, 500);
    end
    check("square_end_mag", int'(a_mag), 0);

    // Step to +20000: one rise, level holds while dc converges.
    push(0, 1, 500);
    drive(0, 20000, 8000);
    check("step_hold_mag", int'(a_mag), 1);

    // +-3000 square on the +20000 offset.
    push(0, 0, 4095);
    drive(0, 17000, 500);
    push(0, 1, 500);
    drive(0, 23000, 500);
    push(0, 0, 500);
    drive(0, 17000, 500);
    push(0, 1, 500);
    drive(0, 23000, 500);
    check("offset_sq_mag", int'(a_mag), 1);

    // Motor off while high: level drops silently, half_period holds.
    a_en = 1'b0;
    drive(0, 23000, 10);
    check("disable_mag", int'(a_mag), 0);
    check("disable_hp", int'(a_hp), 500);
    a_en = 1'b1;
    push(0, 1, 3);
    drive(0, 8000, 2000);
    check("reenable_mag", int'(a_mag), 1);

    // Reset mid-operation, without a tick.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mag", int'(a_mag), 0);
    check("midrst_hp", int'(a_hp), 0);
    check("midrst_stb", int'(a_stb), 0);
    rst = 1'b0;

    // Edges 5000 ticks apart saturate the half-period.
    push(0, 1, 3);
    drive(0, 8000, 5000);
    push(0, 0, 4095);
    drive(0, -8000, 10);
    check("sat_end_mag", int'(a_mag), 0);

    // Threshold is strict: |ac| == HYST never qualifies (dc stays 0 here).
    drive(1, 1024, 3);
    check("b_eq_hyst_up_mag", int'(b_mag), 0);
    drive(1, 0, 2);
    push(1, 1, 8);
    drive(1, 1025, 3);
    check("b_over_hyst_up_mag", int'(b_mag), 1);
    drive(1, -1024, 3);
    check("b_eq_hyst_dn_mag", int'(b_mag), 1);
    push(1, 0, 6);
    drive(1, -1025, 3);
    check("b_over_hyst_dn_mag", int'(b_mag), 0);

    repeat (4) @(negedge clk);
    check("a_pending_edges", a_q.size(), 0);
    check("b_pending_edges", b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
